// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Drives a shared hex decoder nibble and active-low anodes.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   load       : one-cycle strobe, captures value/digit_en
//   value      : four nibbles, digit 0 in value[3:0]
//   digit_en   : per-digit enable, 0 keeps digit dark
//   hex_out    : nibble for the current digit (registered)
//   anode      : active-low digit select (registered)
//   frame_done : pulse on the last cycle of digit 3's slot
module seven_segment_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  output logic [3:0]  hex_out,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK =
    CW'(BLANK_CYCLES);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  logic [15:0]   shadow_val_q, shadow_val_d;
  logic [3:0]    shadow_en_q, shadow_en_d;
  logic          pending_q, pending_d;
  logic [15:0]   active_val_q, active_val_d;
  logic [3:0]    active_en_q, active_en_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [3:0]    hex_q, hex_d;
  logic [3:0]    anode_q, anode_d;
  logic          fd_q, fd_d;

  logic wrap;
  logic boundary;
  logic [3:0] nib_d;

  assign wrap     = (cnt_q == CNT_LAST);
  assign boundary = wrap && (idx_q == 2'd3);

  // Slot counter and digit index
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Double buffering: shadow always tracks the last
  // load; active only changes at the frame boundary.
  // A load on the boundary itself bypasses the shadow.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_en_d  = shadow_en_q;
    pending_d    = pending_q;
    active_val_d = active_val_q;
    active_en_d  = active_en_q;
    if (load) begin
      shadow_val_d = value;
      shadow_en_d  = digit_en;
      pending_d    = 1'b1;
    end
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        active_val_d = value;
        active_en_d  = digit_en;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_en_d  = shadow_en_q;
      end
    end
  end

  // Blank / drive phase within a slot
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK: begin
        if (cnt_d == CNT_BLANK) state_d = DRIVE;
      end
      DRIVE: begin
        if (wrap) state_d = BLANK;
      end
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    nib_d = 4'h0;
    unique case (idx_d)
      2'd0: nib_d = active_val_d[3:0];
      2'd1: nib_d = active_val_d[7:4];
      2'd2: nib_d = active_val_d[11:8];
      2'd3: nib_d = active_val_d[15:12];
      default: nib_d = 4'h0;
    endcase
  end

  // Outputs are computed from next state so the
  // registered outputs line up with cnt_q/idx_q.
  always_comb begin
    anode_d = 4'hF;
    if (state_d == DRIVE)
      anode_d[idx_d] = ~active_en_d[idx_d];
    hex_d = hex_q;
    if (cnt_d == '0) hex_d = nib_d;
    fd_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val_q <= '0;
      shadow_en_q  <= '0;
      pending_q    <= 1'b0;
      active_val_q <= '0;
      active_en_q  <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      state_q      <= BLANK;
      hex_q        <= 4'h0;
      anode_q      <= 4'hF;
      fd_q         <= 1'b0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_en_q  <= shadow_en_d;
      pending_q    <= pending_d;
      active_val_q <= active_val_d;
      active_en_q  <= active_en_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      hex_q        <= hex_d;
      anode_q      <= anode_d;
      fd_q         <= fd_d;
    end
  end

  assign hex_out    = hex_q;
  assign anode      = anode_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Self-checking bench for seven_segment_scan_ctrl.
// Scoreboard of per-cycle expected outputs.
module tb_seven_segment_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  hex_out;
  logic [3:0]  anode;
  logic        frame_done;

  seven_segment_scan_ctrl #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .digit_en  (digit_en),
    .hex_out   (hex_out),
    .anode     (anode),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int t;
  int fd_cnt;
  int fd_first;
  logic [15:0] m_val, m_sv;
  logic [3:0]  m_en, m_se;
  logic        m_pend;
  logic [8:0]  sb[$];
  logic        no_a;
  logic [3:0]  prev_hex;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h",
               tag, t, got, exp);
    end
  endtask

  function automatic logic [8:0] mexp();
    int c;
    int i;
    logic [3:0] an;
    c = t % 8;
    i = (t / 8) % 4;
    an = 4'hF;
    if (c >= 2 && m_en[i]) an[i] = 1'b0;
    return {an, m_val[4*i +: 4], (c == 7 && i == 3)};
  endfunction

  task automatic model_reset();
    t = 0;
    m_val = '0;
    m_sv = '0;
    m_en = '0;
    m_se = '0;
    m_pend = 1'b0;
    sb.delete();
    chk("rst_state", {anode, hex_out, frame_done},
        {4'hF, 4'h0, 1'b0});
    prev_hex = hex_out;
  endtask

  task automatic step(input logic ld,
                      input logic [15:0] v,
                      input logic [3:0] en);
    logic [8:0] got;
    load = ld;
    value = v;
    digit_en = en;
    if (t % 32 == 31) begin
      if (ld) begin
        m_val = v;
        m_en = en;
      end else if (m_pend) begin
        m_val = m_sv;
        m_en = m_se;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sv = v;
      m_se = en;
      m_pend = 1'b1;
    end
    t++;
    sb.push_back(mexp());
    @(posedge clk);
    #1;
    load = 1'b0;
    got = {anode, hex_out, frame_done};
    chk("out", got, sb.pop_front());
    chk("onehot", ($countones(~anode) <= 1), 1);
    if (hex_out != prev_hex)
      chk("hex_stable", anode, 4'hF);
    if (no_a && anode != 4'hF)
      chk("no_a", hex_out == 4'hA, 0);
    if (frame_done) begin
      fd_cnt++;
      if (fd_first < 0) fd_first = t;
    end
    prev_hex = hex_out;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic to_boundary();
    while (t % 32 != 31) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic frame_check(input logic [15:0] ans,
                             input logic [15:0] hexs);
    int c;
    int i;
    for (int k = 0; k < 32; k++) begin
      if (t % 32 == 31 && k > 0) break;
      step(1'b0, 16'h0, 4'h0);
      c = t % 8;
      i = (t / 8) % 4;
      if (c == 4) begin
        chk("dir_an", anode, ans[4*i +: 4]);
        chk("dir_hex", hex_out, hexs[4*i +: 4]);
      end
      if (c == 1) chk("dir_blank", anode, 4'hF);
    end
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    value = '0;
    digit_en = '0;
    no_a = 1'b0;
    fd_cnt = 0;
    fd_first = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {anode, frame_done}, {4'hF, 1'b0});
    reset = 1'b0;
    model_reset();

    // 1: idle after reset
    idle(64);
    chk("fd_count", fd_cnt, 2);
    chk("fd_first", fd_first, 31);

    // 2: simple load, applied at the next boundary
    idle(5);
    step(1'b1, 16'h1234, 4'hF);
    to_boundary();
    frame_check(16'h7BDE, 16'h1234);

    // 3: last load in a frame wins
    idle(1);
    no_a = 1'b1;
    step(1'b1, 16'hAAAA, 4'hF);
    idle(3);
    step(1'b1, 16'h5555, 4'hF);
    to_boundary();
    frame_check(16'h7BDE, 16'h5555);
    no_a = 1'b0;

    // 4: load right on the boundary cycle
    to_boundary();
    chk("at_boundary", frame_done, 1);
    step(1'b1, 16'hBEEF, 4'b0101);
    frame_check(16'hFBFE, 16'hBEEF);

    // 5: reset in digit 2's drive window
    while (t % 32 != 17) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h9999, 4'hF);
    idle(1);
    chk("pre_rst_an", anode, 4'b1011);
    reset = 1'b1;
    #1;
    chk("async_an", anode, 4'hF);
    chk("async_fd", frame_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle(64);

    // 6: random loads
    for (int k = 0; k < 1000; k++) begin
      step(($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
